// File: rtl/timer_counter_pw_if.sv
//------------------------------------------------------------------------------
// Module      : timer_counter_pw_if
// Description : Control/status bundle for the parametrised timer counter.
//               The master side drives the controls; the slave side (the
//               counter) drives count, pulses, sticky status and irq.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface timer_counter_pw_if #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
);
  // Controls
  logic             enable;
  logic             clk_ena;
  logic             up_down;
  logic             load;
  logic [1:0]       mode;
  logic [WIDTH-1:0] start_counter;
  logic [WIDTH-1:0] compare_value;
  logic [PSC_W-1:0] psc_div;
  logic             clr_status;
  logic [2:0]       irq_en;
  // Results
  logic [WIDTH-1:0] count;
  logic             running;
  logic             overflow;
  logic             underflow;
  logic             cmp_match;
  logic [2:0]       status;
  logic             irq;

  modport master (
    output enable, clk_ena, up_down, load, mode, start_counter,
           compare_value, psc_div, clr_status, irq_en,
    input  count, running, overflow, underflow, cmp_match, status, irq
  );

  modport slave (
    input  enable, clk_ena, up_down, load, mode, start_counter,
           compare_value, psc_div, clr_status, irq_en,
    output count, running, overflow, underflow, cmp_match, status, irq
  );
endinterface

`default_nettype wire

// File: rtl/timer_counter_pw.sv
//------------------------------------------------------------------------------
// Module      : timer_counter_pw
// Description : Up/down timer counter with programmable prescaler,
//               free-run / auto-reload / one-shot modes, compare match,
//               wrap-aligned overflow/underflow pulses and sticky status
//               with a maskable interrupt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_counter_pw #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  timer_counter_pw_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] c_PSC_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       c_MODE_RELOAD  = 2'b01;
  localparam logic [1:0]       c_MODE_ONESHOT = 2'b10;

  logic [WIDTH-1:0] count_q, count_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             halted_q, halted_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             cmp_q, cmp_d;
  logic [2:0]       status_q, status_d;
  logic             tick;
  logic             wrap;

  // Next-state logic: prescaler, count/wrap, event pulses and sticky status
  always_comb begin
    tick     = 1'b0;
    wrap     = 1'b0;
    count_d  = count_q;
    psc_d    = psc_q;
    halted_d = halted_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    cmp_d    = 1'b0;
    // Registered pulses set status; a coincident clear loses to them.
    status_d = (bus.clr_status ? 3'b000 : status_q) | {cmp_q, udf_q, ovf_q};

    if (bus.load) begin
      count_d  = bus.start_counter;
      psc_d    = '0;
      halted_d = 1'b0;
    end else if (bus.enable && bus.clk_ena && !halted_q) begin
      // >= so a divider lowered below the current count ticks at once
      if (psc_q >= bus.psc_div) begin
        psc_d = '0;
        tick  = 1'b1;
      end else begin
        psc_d = psc_q + c_PSC_ONE;
      end
    end

    if (tick) begin
      if (bus.up_down) begin
        if (count_q == c_MAX) begin
          wrap  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + c_ONE;
        end
      end else begin
        if (count_q == '0) begin
          wrap  = 1'b1;
          udf_d = 1'b1;
        end else begin
          count_d = count_q - c_ONE;
        end
      end

      if (wrap) begin
        if (bus.mode == c_MODE_RELOAD) begin
          count_d = bus.start_counter;
        end else begin
          count_d = bus.up_down ? '0 : c_MAX;
          if (bus.mode == c_MODE_ONESHOT) begin
            halted_d = 1'b1;
          end
        end
      end

      // Compare against the value the count is about to take
      cmp_d = (count_d == bus.compare_value);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      psc_q    <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      cmp_q    <= 1'b0;
      status_q <= 3'b000;
    end else begin
      count_q  <= count_d;
      psc_q    <= psc_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.running   = ~halted_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.cmp_match = cmp_q;
  assign bus.status    = status_q;
  assign bus.irq       = |(status_q & bus.irq_en);

endmodule

`default_nettype wire

// File: tb/tb_timer_counter_pw.sv
//------------------------------------------------------------------------------
// Module      : tb_timer_counter_pw
// Description : Self-checking bench for timer_counter_pw: vector table,
//               directed multi-cycle sequences and randomized stimulus
//               against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_counter_pw;

  localparam int WIDTH = 8;
  localparam int PSC_W = 4;
  localparam int MAXV  = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_counter_pw_if #(.WIDTH(WIDTH), .PSC_W(PSC_W)) bus ();

  timer_counter_pw #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] cnt, input logic ovf,
                           input logic udf, input logic cmp, input logic [2:0] st,
                           input logic run, input logic irq);
    check({tag, ".count"},     {24'd0, bus.count},     {24'd0, cnt});
    check({tag, ".overflow"},  {31'd0, bus.overflow},  {31'd0, ovf});
    check({tag, ".underflow"}, {31'd0, bus.underflow}, {31'd0, udf});
    check({tag, ".cmp_match"}, {31'd0, bus.cmp_match}, {31'd0, cmp});
    check({tag, ".status"},    {29'd0, bus.status},    {29'd0, st});
    check({tag, ".running"},   {31'd0, bus.running},   {31'd0, run});
    check({tag, ".irq"},       {31'd0, bus.irq},       {31'd0, irq});
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    rst               = 1'b0;
    bus.enable        = 1'b1;
    bus.clk_ena       = 1'b1;
    bus.up_down       = 1'b1;
    bus.load          = 1'b0;
    bus.mode          = 2'b00;
    bus.start_counter = 8'h00;
    bus.compare_value = 8'h10;
    bus.psc_div       = 4'd0;
    bus.clr_status    = 1'b0;
    bus.irq_en        = 3'b101;
  endtask

  // ---------------- behavioural reference model ----------------
  int       m_cnt, m_psc;
  bit       m_halt, m_ovf, m_udf, m_cmp;
  bit [2:0] m_st;

  function automatic void model_step();
    bit [2:0] nst;
    bit       tk, o, u, c;
    int       n;
    if (rst) begin
      m_cnt = 0; m_psc = 0; m_halt = 0;
      m_ovf = 0; m_udf = 0; m_cmp = 0; m_st = 0;
      return;
    end
    nst = (bus.clr_status ? 3'b000 : m_st) | {m_cmp, m_udf, m_ovf};
    tk = 0; o = 0; u = 0; c = 0;
    if (bus.load) begin
      m_cnt = int'(bus.start_counter); m_psc = 0; m_halt = 0;
    end else if (bus.enable && bus.clk_ena && !m_halt) begin
      if (m_psc >= int'(bus.psc_div)) begin
        m_psc = 0; tk = 1;
      end else begin
        m_psc = m_psc + 1;
      end
    end
    if (tk) begin
      n = bus.up_down ? m_cnt + 1 : m_cnt - 1;
      if (n > MAXV || n < 0) begin
        if (bus.up_down) o = 1; else u = 1;
        if (bus.mode == 2'b01) n = int'(bus.start_counter);
        else                    n = (n + MAXV + 1) % (MAXV + 1);
        if (bus.mode == 2'b10) m_halt = 1;
      end
      m_cnt = n;
      c = (n == int'(bus.compare_value));
    end
    m_ovf = o; m_udf = u; m_cmp = c; m_st = nst;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       ld;
    logic [7:0] st;
    logic       up;
    logic [1:0] md;
    logic       clr;
    logic [7:0] e_cnt;
    logic       e_ovf, e_udf, e_cmp;
    logic [2:0] e_st;
    logic       e_run, e_irq;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int n_ovf, n_udf, ok_cnt;

    tbl[0]  = '{1'b1, 8'hFD, 1'b1, 2'b00, 1'b0, 8'hFD, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'hFD, 1'b1, 2'b00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'hFD, 1'b1, 2'b00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'hFD, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'hFD, 1'b1, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'hFD, 1'b1, 2'b00, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h0E, 1'b1, 2'b00, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h0E, 1'b1, 2'b00, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h0E, 1'b1, 2'b00, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h0E, 1'b1, 2'b00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h0E, 1'b1, 2'b00, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h55, 1'b1, 2'b00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h01, 1'b0, 2'b10, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h01, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'h01, 1'b0, 2'b10, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h01, 1'b0, 2'b10, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 8'h01, 1'b0, 2'b10, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 8'h20, 1'b1, 2'b01, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};

    // Reset state
    defaults();
    rst = 1'b1;
    cycle();
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    rst = 1'b0;

    // Table-driven sequence
    for (int i = 0; i < 18; i++) begin
      bus.load          = tbl[i].ld;
      bus.start_counter = tbl[i].st;
      bus.up_down       = tbl[i].up;
      bus.mode          = tbl[i].md;
      bus.clr_status    = tbl[i].clr;
      cycle();
      check_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_udf,
                tbl[i].e_cmp, tbl[i].e_st, tbl[i].e_run, tbl[i].e_irq);
    end

    // Prescaler: divide by 4, strobe every other clock, count down from 02
    defaults();
    bus.compare_value = 8'h80;
    bus.psc_div = 4'd3; bus.up_down = 1'b0;
    bus.load = 1'b1; bus.start_counter = 8'h02;
    cycle();
    bus.load = 1'b0;
    n_udf = 0;
    for (int i = 0; i < 32; i++) begin
      bus.clk_ena = (i % 2 == 0);
      cycle();
      if (bus.underflow) n_udf++;
      if (i == 5)  check("psc.hold_before_tick", {24'd0, bus.count}, 32'h02);
      if (i == 6)  check("psc.first_tick",       {24'd0, bus.count}, 32'h01);
      if (i == 14) check("psc.second_tick",      {24'd0, bus.count}, 32'h00);
      if (i == 22) check("psc.wrap_udf",         {31'd0, bus.underflow}, 32'h1);
      if (i == 23) check("psc.udf_one_wide",     {31'd0, bus.underflow}, 32'h0);
    end
    check("psc.final_count", {24'd0, bus.count}, 32'hFE);
    check("psc.udf_pulses",  n_udf, 1);

    // Auto-reload: F0..FF, period 16 ticks
    defaults();
    bus.compare_value = 8'h00;
    bus.mode = 2'b01; bus.start_counter = 8'hF0; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    n_ovf = 0; ok_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      if (bus.overflow) begin
        n_ovf++;
        if (bus.count == 8'hF0) ok_cnt++;
      end
    end
    check("reload.ovf_pulses", n_ovf, 3);
    check("reload.count_at_ovf", ok_cnt, 3);

    // One-shot: halts at FF for 20 strobes, re-armed by load, cleared by rst
    defaults();
    bus.compare_value = 8'h80;
    bus.mode = 2'b10; bus.up_down = 1'b0; bus.start_counter = 8'h01; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    n_udf = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (bus.underflow) n_udf++;
    end
    check("oneshot.count_held", {24'd0, bus.count}, 32'hFF);
    check("oneshot.running",    {31'd0, bus.running}, 32'h0);
    check("oneshot.udf_pulses", n_udf, 1);
    bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    check("oneshot.rearm_running", {31'd0, bus.running}, 32'h1);
    cycle();
    cycle();
    check("oneshot.halt_again", {31'd0, bus.running}, 32'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("oneshot.rst_running", {31'd0, bus.running}, 32'h1);

    // Reset mid-count with status=111
    defaults();
    bus.compare_value = 8'h00;
    bus.start_counter = 8'hFF; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    cycle();
    check_all("ovfcmp", 8'h00, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    cycle();
    bus.up_down = 1'b0; bus.start_counter = 8'h00; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    cycle();
    cycle();
    bus.start_counter = 8'h55; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0; bus.enable = 1'b0;
    check_all("pre_rst", 8'h55, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);

    // Randomized stimulus against the behavioural model
    defaults();
    rst = 1'b1;
    model_step();
    cycle();
    for (int i = 0; i < 3000; i++) begin
      rst               = ($urandom_range(0, 99) == 0);
      bus.enable        = ($urandom_range(0, 9) != 0);
      bus.clk_ena       = ($urandom_range(0, 1) == 1);
      bus.up_down       = ($urandom_range(0, 31) != 0) ? bus.up_down : ~bus.up_down;
      bus.load          = ($urandom_range(0, 39) == 0);
      bus.mode          = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(0, 3)) : bus.mode;
      bus.start_counter = 8'($urandom_range(0, 255));
      bus.compare_value = ($urandom_range(0, 99) == 0) ? 8'($urandom_range(0, 255)) : bus.compare_value;
      bus.psc_div       = 4'($urandom_range(0, 3));
      bus.clr_status    = ($urandom_range(0, 15) == 0);
      bus.irq_en        = 3'($urandom_range(0, 7));
      model_step();
      cycle();
      check_all("rand", 8'(m_cnt), m_ovf, m_udf, m_cmp, m_st, ~m_halt,
                |(m_st & bus.irq_en));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
